// File: rtl/dmem_arbiter_pkg.sv
// Shared types and helpers for the two-port data-memory arbiter.
// Holds the FSM state encoding, the word width and the address/lock-width helpers.
package dmem_arbiter_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StOwn0 = 2'd1,
    StOwn1 = 2'd2
  } arb_state_e;

  // Width needed to hold a lock counter that counts up to max_lock inclusive.
  function automatic int unsigned lock_w(input int unsigned max_lock);
    return (max_lock < 1) ? 1 : $clog2(max_lock + 1);
  endfunction

  function automatic logic addr_in_range(input logic [WORD_W-1:0] addr,
                                         input int unsigned       depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Combinational two-way round-robin pick.
// On a tie the port that was not granted last wins; the result is one-hot or zero.
module dmem_arbiter_rr_pick2 (
  input  logic       req0,
  input  logic       req1,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (req0 && req1) begin
      gnt = last ? 2'b01 : 2'b10;
    end else if (req0) begin
      gnt = 2'b01;
    end else if (req1) begin
      gnt = 2'b10;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter for the single-ported data memory, with an optional
// bounded lock, registered read-data return and out-of-range address rejection.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned MAX_LOCK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic              lock0,
  input  logic              lock1,
  input  logic [WORD_W-1:0] addr0,
  input  logic [WORD_W-1:0] addr1,
  input  logic [WORD_W-1:0] wdata0,
  input  logic [WORD_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [WORD_W-1:0] rdata0,
  output logic [WORD_W-1:0] rdata1,
  output logic              err0,
  output logic              err1,
  output logic              mem_read,
  output logic              mem_write,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata
);

  localparam int unsigned     LockW   = lock_w(MAX_LOCK);
  localparam logic [LockW-1:0] LockMax = LockW'(MAX_LOCK);

  arb_state_e       state_q, state_d;
  logic             last_q, last_d;
  logic [LockW-1:0] lock_cnt_q, lock_cnt_d;
  logic [LockW-1:0] lock_cnt_inc;

  logic [1:0]        rr_gnt;
  logic              ok0, ok1;
  logic              sel_we, sel_ok, sel_lock;
  logic [WORD_W-1:0] sel_addr, sel_wdata;
  logic              rvalid0_q, rvalid1_q, err0_q, err1_q;

  dmem_arbiter_rr_pick2 u_rr_pick2 (
    .req0 (req0),
    .req1 (req1),
    .last (last_q),
    .gnt  (rr_gnt)
  );

  assign ok0          = addr_in_range(addr0, DEPTH);
  assign ok1          = addr_in_range(addr1, DEPTH);
  assign lock_cnt_inc = lock_cnt_q + LockW'(1);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      last_q     <= 1'b1;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  // Next state. lock_cnt counts the granted cycles of the current locked run,
  // so a run is released on the grant that brings it to MAX_LOCK.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    lock_cnt_d = lock_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (gnt0 || gnt1) begin
          last_d = gnt1;
          if (sel_lock && (MAX_LOCK > 1)) begin
            state_d    = gnt1 ? StOwn1 : StOwn0;
            lock_cnt_d = LockW'(1);
          end
        end
      end
      StOwn0: begin
        if (gnt0 && lock0 && (lock_cnt_inc < LockMax)) begin
          lock_cnt_d = lock_cnt_inc;
        end else begin
          state_d    = StIdle;
          lock_cnt_d = '0;
          last_d     = 1'b0;
        end
      end
      StOwn1: begin
        if (gnt1 && lock1 && (lock_cnt_inc < LockMax)) begin
          lock_cnt_d = lock_cnt_inc;
        end else begin
          state_d    = StIdle;
          lock_cnt_d = '0;
          last_d     = 1'b1;
        end
      end
      default: begin
        state_d    = StIdle;
        lock_cnt_d = '0;
      end
    endcase
  end

  // Outputs: grants (suppressed during reset) and the memory-side mux.
  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    if (!rst) begin
      unique case (state_q)
        StIdle: begin
          gnt0 = rr_gnt[0];
          gnt1 = rr_gnt[1];
        end
        StOwn0:  gnt0 = req0;
        StOwn1:  gnt1 = req1;
        default: ;
      endcase
    end

    sel_we    = gnt1 ? we1    : we0;
    sel_ok    = gnt1 ? ok1    : ok0;
    sel_lock  = gnt1 ? lock1  : lock0;
    sel_addr  = gnt1 ? addr1  : addr0;
    sel_wdata = gnt1 ? wdata1 : wdata0;

    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if ((gnt0 || gnt1) && sel_ok) begin
      mem_read  = ~sel_we;
      mem_write = sel_we;
      mem_addr  = sel_addr;
      mem_wdata = sel_wdata;
    end
  end

  // Response registers; rdata holds until the next read completes on that port.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
    end else begin
      rvalid0_q <= gnt0 & ok0 & ~we0;
      rvalid1_q <= gnt1 & ok1 & ~we1;
      err0_q    <= gnt0 & ~ok0;
      err1_q    <= gnt1 & ~ok1;
      if (gnt0 && ok0 && !we0) begin
        rdata0 <= mem_rdata;
      end
      if (gnt1 && ok1 && !we1) begin
        rdata1 <= mem_rdata;
      end
    end
  end

  // A reset arriving while a response is pending drops it immediately.
  assign rvalid0 = rvalid0_q & ~rst;
  assign rvalid1 = rvalid1_q & ~rst;
  assign err0    = err0_q & ~rst;
  assign err1    = err1_q & ~rst;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: a transaction-level model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_dmem_arbiter;

  localparam int unsigned DEPTH    = 64;
  localparam int unsigned MAX_LOCK = 4;
  localparam int unsigned AW       = $clog2(DEPTH);

  logic        clk, rst;
  logic        req0, req1, we0, we1, lock0, lock1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1;
  logic [31:0] rdata0, rdata1;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int n_vec = 0;
  int n_bad = 0;

  dmem_arbiter #(
    .DEPTH    (DEPTH),
    .MAX_LOCK (MAX_LOCK)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req0      (req0),
    .req1      (req1),
    .we0       (we0),
    .we1       (we1),
    .lock0     (lock0),
    .lock1     (lock1),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .rvalid0   (rvalid0),
    .rvalid1   (rvalid1),
    .rdata0    (rdata0),
    .rdata1    (rdata1),
    .err0      (err0),
    .err1      (err1),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory: synchronous write, combinational read.
  logic [31:0] mem [DEPTH];
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr[AW-1:0]] <= mem_wdata;
  end
  assign mem_rdata = mem[mem_addr[AW-1:0]];

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %b, expected %b", nm, $time, act, exp);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] shadow [DEPTH];
  int          owner    = -1;   // port holding a lock, -1 when free
  int          streak   = 0;    // grants used so far in the locked run
  logic        m_last   = 1'b1;
  logic [1:0]  exp_rv   = 2'b00;
  logic [1:0]  exp_er   = 2'b00;
  logic [31:0] exp_rd0  = '0;
  logic [31:0] exp_rd1  = '0;
  logic        seen_rst = 1'b0;

  always @(negedge clk) begin
    int          g;
    logic        gw, gl, gok;
    logic [31:0] ga, gd;

    if (seen_rst) begin
      chk1 ("m_rvalid0", rvalid0, exp_rv[0] & ~rst);
      chk1 ("m_rvalid1", rvalid1, exp_rv[1] & ~rst);
      chk1 ("m_err0",    err0,    exp_er[0] & ~rst);
      chk1 ("m_err1",    err1,    exp_er[1] & ~rst);
      chk32("m_rdata0",  rdata0,  exp_rd0);
      chk32("m_rdata1",  rdata1,  exp_rd1);
    end

    g = -1;
    if (!rst) begin
      if (owner < 0) begin
        if (req0 && req1) g = m_last ? 0 : 1;
        else if (req0)    g = 0;
        else if (req1)    g = 1;
      end else if ((owner == 0) ? req0 : req1) begin
        g = owner;
      end
    end
    gw  = (g == 1) ? we1    : we0;
    gl  = (g == 1) ? lock1  : lock0;
    ga  = (g == 1) ? addr1  : addr0;
    gd  = (g == 1) ? wdata1 : wdata0;
    gok = (g >= 0) && (ga < DEPTH);

    chk1 ("m_gnt0",      gnt0,      g == 0);
    chk1 ("m_gnt1",      gnt1,      g == 1);
    chk1 ("m_mem_read",  mem_read,  gok && !gw);
    chk1 ("m_mem_write", mem_write, gok && gw);
    chk32("m_mem_addr",  mem_addr,  gok ? ga : 32'h0);
    chk32("m_mem_wdata", mem_wdata, gok ? gd : 32'h0);

    if (rst) begin
      owner    = -1;
      streak   = 0;
      m_last   = 1'b1;
      exp_rv   = 2'b00;
      exp_er   = 2'b00;
      exp_rd0  = '0;
      exp_rd1  = '0;
      seen_rst = 1'b1;
    end else begin
      exp_rv = 2'b00;
      exp_er = 2'b00;
      if (g >= 0) begin
        if (!gok) begin
          exp_er[g] = 1'b1;
        end else if (gw) begin
          shadow[ga[AW-1:0]] = gd;
        end else begin
          exp_rv[g] = 1'b1;
          if (g == 0) exp_rd0 = shadow[ga[AW-1:0]];
          else        exp_rd1 = shadow[ga[AW-1:0]];
        end
      end
      if (owner < 0) begin
        if (g >= 0) begin
          m_last = (g == 1);
          if (gl && MAX_LOCK > 1) begin
            owner  = g;
            streak = 1;
          end
        end
      end else if (g >= 0 && gl && streak + 1 < MAX_LOCK) begin
        streak++;
      end else begin
        m_last = (owner == 1);
        owner  = -1;
        streak = 0;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]    = 32'hC0DE_0000 | i;
      shadow[i] = 32'hC0DE_0000 | i;
    end
    mem[5]    = 32'h0000_00A5;
    shadow[5] = 32'h0000_00A5;
    rst = 1'b1;
    {req0, req1, we0, we1, lock0, lock1} = '0;
    {addr0, addr1, wdata0, wdata1} = '0;
    step();
    step();
    chk1 ("rst_gnt0",   gnt0,    1'b0);
    chk1 ("rst_gnt1",   gnt1,    1'b0);
    chk1 ("rst_rvalid", rvalid0, 1'b0);
    chk32("rst_rdata0", rdata0,  32'h0);
    rst = 1'b0;

    // Single read, addr 5
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'd5;
    #1;
    chk1 ("rd5_gnt0",  gnt0,     1'b1);
    chk1 ("rd5_mread", mem_read, 1'b1);
    chk32("rd5_maddr", mem_addr, 32'd5);
    step();
    req0 = 1'b0;
    #1;
    chk1 ("rd5_rvalid", rvalid0, 1'b1);
    chk32("rd5_rdata",  rdata0,  32'h0000_00A5);

    // Port 1 read, leaves last on port 1
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'd7;
    #1;
    chk1("rd7_gnt1", gnt1, 1'b1);
    step();
    req1 = 1'b0;
    #1;
    chk1 ("rd5_rvalid_drop", rvalid0, 1'b0);
    chk32("rd7_rdata1",      rdata1,  32'hC0DE_0007);

    // Both write addr 10 every cycle: grants alternate 0,1,0,1
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'd10; wdata0 = 32'h100;
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'd10; wdata1 = 32'h200;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk1("alt_gnt0", gnt0, (k == 0) || (k == 2));
      chk1("alt_gnt1", gnt1, (k == 1) || (k == 3));
      step();
      if (gnt0 === 1'b0 && (k == 0 || k == 2)) wdata0 = wdata0; // requester holds
      if (k == 0 || k == 2) wdata0 = wdata0 + 32'h1;
      else                  wdata1 = wdata1 + 32'h1;
    end
    req1 = 1'b0; we1 = 1'b0;
    we0 = 1'b0; addr0 = 32'd10;
    #1;
    chk1("alt_rd_gnt0", gnt0, 1'b1);
    step();
    req0 = 1'b0;
    #1;
    chk32("alt_last_writer", rdata0, 32'h201);

    // Port 1 locked continuously with port 0 waiting: 4 x gnt1 then gnt0
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'd1;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'd2; lock1 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk1("lock_gnt1", gnt1, k < 4);
      chk1("lock_gnt0", gnt0, k == 4);
      step();
    end
    req0 = 1'b0; req1 = 1'b0; lock1 = 1'b0;

    // Read-modify-write on addr 20 under lock0; port 1 must wait
    req0 = 1'b1; lock0 = 1'b1; we0 = 1'b0; addr0 = 32'd20;
    #1;
    chk1("rmw_rd_gnt0", gnt0, 1'b1);
    step();
    we0 = 1'b1; lock0 = 1'b0; wdata0 = 32'h55;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'd20;
    #1;
    chk1 ("rmw_wr_gnt0",   gnt0,   1'b1);
    chk1 ("rmw_wr_gnt1",   gnt1,   1'b0);
    chk32("rmw_rd_rdata0", rdata0, 32'hC0DE_0014);
    step();
    req0 = 1'b0; we0 = 1'b0;
    #1;
    chk1("rmw_gnt1", gnt1, 1'b1);
    step();
    req1 = 1'b0;
    #1;
    chk32("rmw_rdata1", rdata1, 32'h55);

    // Out-of-range write
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'd64; wdata0 = 32'hDEAD;
    #1;
    chk1 ("bad_gnt0",   gnt0,      1'b1);
    chk1 ("bad_mwrite", mem_write, 1'b0);
    chk32("bad_maddr",  mem_addr,  32'h0);
    step();
    req0 = 1'b0; we0 = 1'b0;
    #1;
    chk1("bad_err0",   err0,    1'b1);
    chk1("bad_rvalid", rvalid0, 1'b0);
    step();
    chk1("bad_err_drop", err0, 1'b0);

    // Port 0 writes addr 3, port 1 reads it back next cycle
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'd3; wdata0 = 32'h11;
    #1;
    chk1("wr3_gnt0", gnt0, 1'b1);
    step();
    req0 = 1'b0; we0 = 1'b0;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'd3;
    #1;
    chk1("rd3_gnt1", gnt1, 1'b1);
    step();
    req1 = 1'b0;
    #1;
    chk1 ("rd3_rvalid1", rvalid1, 1'b1);
    chk32("rd3_rdata1",  rdata1,  32'h11);

    // Reset the cycle after a granted, locked read
    req0 = 1'b1; we0 = 1'b0; lock0 = 1'b1; addr0 = 32'd5;
    #1;
    chk1("rstop_gnt0", gnt0, 1'b1);
    step();
    req0 = 1'b0; lock0 = 1'b0;
    rst = 1'b1;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'd6;
    #1;
    chk1("rstop_rvalid0", rvalid0,  1'b0);
    chk1("rstop_gnt1",    gnt1,     1'b0);
    chk1("rstop_mread",   mem_read, 1'b0);
    step();
    rst = 1'b0;
    #1;
    chk1 ("rstop_unlocked", gnt1,   1'b1);
    chk32("rstop_rdata0",   rdata0, 32'h0);
    step();
    req1 = 1'b0;
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
